// File: rtl/frame_1010_pkg.sv
// Shared types and constants for the 1010-preamble frame transmitter.
package frame_1010_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    DATA = 3'd2,
    PAR  = 3'd3,
    GAP  = 3'd4
  } state_t;

  localparam logic [3:0]  PREAMBLE = 4'b1010;
  localparam int unsigned PRE_LEN  = 4;

  // Bits needed to count 0..v-1; never less than one bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load, MSB-first shift register; zeros shift in at the LSB.
module piso_shift_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] par_i,
  output logic         msb_o
);

  logic [W-1:0] sr_q;

  // Load has priority so a chained frame can capture on the old frame's final edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= par_i;
    end else if (shift_i) begin
      sr_q <= W'(sr_q << 1);
    end
  end

  assign msb_o = sr_q[W-1];

endmodule

// File: rtl/frame_1010_tx.sv
// Serial frame transmitter: preamble 1010, payload MSB first, optional even parity, zero gap.
// Define FRAME_1010_TX_PARITY_EN to append the parity bit after the payload.
module frame_1010_tx
  import frame_1010_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned GAP_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  output logic              ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = clog2(max3(PRE_LEN, DATA_W, GAP_BITS));
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_BITS == 0) ? 0 : GAP_BITS - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tx_q, tx_d;
  logic              ready_q, busy_q, done_q;
  logic              accept_c, shift_c, last_c;
  logic [1:0]        pre_idx_c;
  logic              sr_msb;
  logic              par_bit;

  // True when (s, c) is the cycle carrying the final bit of a frame.
  function automatic logic is_last(input state_t s, input logic [CNT_W-1:0] c);
    logic r;
    r = (s == GAP) && (c == GAP_LAST);
`ifdef FRAME_1010_TX_PARITY_EN
    if (GAP_BITS == 0) r = (s == PAR);
`else
    if (GAP_BITS == 0) r = (s == DATA) && (c == DATA_LAST);
`endif
    return r;
  endfunction

  piso_shift_reg #(
    .W (DATA_W)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .load_i  (accept_c),
    .shift_i (shift_c),
    .par_i   (data_in),
    .msb_o   (sr_msb)
  );

`ifdef FRAME_1010_TX_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (accept_c) begin
      par_q <= ^data_in;
    end
  end

  assign par_bit = par_q;
`else
  assign par_bit = 1'b0;
`endif

  // Next preamble bit: the bit on tx now is PREAMBLE[3-cnt], the next one PREAMBLE[2-cnt].
  assign pre_idx_c = 2'(CNT_W'(PRE_LEN - 2) - cnt_q);

  // Next state, counter and next tx bit; tx_d is the value the line shows next cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tx_d     = 1'b0;
    accept_c = 1'b0;
    shift_c  = 1'b0;
    last_c   = is_last(state_q, cnt_q);

    case (state_q)
      IDLE: begin
        accept_c = ready_q & load;
      end
      PRE: begin
        if (cnt_q == PRE_LAST) begin
          state_d = DATA;
          cnt_d   = '0;
          tx_d    = sr_msb;
          shift_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          tx_d  = PREAMBLE[pre_idx_c];
        end
      end
      DATA: begin
        if (cnt_q != DATA_LAST) begin
          cnt_d   = cnt_q + CNT_W'(1);
          tx_d    = sr_msb;
          shift_c = 1'b1;
        end
`ifdef FRAME_1010_TX_PARITY_EN
        else begin
          state_d = PAR;
          tx_d    = par_bit;
        end
`else
        else if (GAP_BITS != 0) begin
          state_d = GAP;
          cnt_d   = '0;
        end
`endif
      end
`ifdef FRAME_1010_TX_PARITY_EN
      PAR: begin
        if (GAP_BITS != 0) begin
          state_d = GAP;
          cnt_d   = '0;
        end
      end
`endif
      GAP: begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A load present on the final bit cycle chains the next frame with no dead cycle.
    if (last_c) begin
      state_d  = IDLE;
      cnt_d    = '0;
      tx_d     = 1'b0;
      shift_c  = 1'b0;
      accept_c = load;
    end

    if (accept_c) begin
      state_d = PRE;
      cnt_d   = '0;
      tx_d    = PREAMBLE[PRE_LEN-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tx_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      ready_q <= (state_d == IDLE);
      busy_q  <= (state_d != IDLE);
      done_q  <= is_last(state_d, cnt_d);
    end
  end

  assign ready = ready_q;
  assign tx    = tx_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: doc/frame_1010_tx.md
Name: frame_1010_tx

Overview:
Serial frame transmitter, the send-side counterpart of the team's Mealy "1010" overlapping sequence detectors.
- Accepts a parallel word through a valid/ready handshake.
- Serialises it on one line as: 4-bit preamble 1,0,1,0, then the data MSB first, then optional parity, then an idle gap of zeros.
- Provides bench stimulus and a link source for the detector family.

Parameters:
DATA_W, 8, payload width in bits (>=1)
GAP_BITS, 2, number of forced-0 bits after each frame (>=0; 0 allows back-to-back frames)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
data_in  input  DATA_W  payload, sampled on accepted load
load  input  1  request to send data_in
ready  output  1  block can accept load this cycle
tx  output  1  serial line, registered
busy  output  1  frame in progress (preamble/data/parity/gap)
done  output  1  one-cycle pulse on the last bit cycle of a frame

Behaviour:
- Reset and clocking:
  - One clock.
  - Reset is asynchronous and active-high.
  - While rst=1: tx=0, busy=0, done=0, ready=0, state=IDLE, counters cleared.
  - ready rises the first cycle after rst deasserts.
- States:
  - IDLE, PRE, DATA, PAR (only with the optional feature), GAP.
  - State is binary-encoded with a default arm returning to IDLE.
- IDLE: tx=0, ready=1, busy=0.
  - load=1 at a rising edge captures data_in into the shift register, sets bit counter=0 and goes to PRE.
  - load while ready=0 is ignored; it is not queued.
- PRE: drives 1,0,1,0 on four consecutive cycles, then goes to DATA.
- DATA: drives shift[DATA_W-1] and shifts left each cycle for DATA_W cycles, then goes to PAR, or to GAP/IDLE.
- GAP: drives 0 for GAP_BITS cycles, then goes to IDLE.
  - GAP_BITS=0 skips GAP entirely.
- Timing:
  - tx is registered: the first preamble bit is visible in the cycle after the accepting edge.
  - Frame length L = 4 + DATA_W + P + GAP_BITS cycles, where P=1 with parity and 0 without.
  - ready is low for exactly L cycles and high on cycle L+1.
  - With load held high, the next frame's first bit follows immediately. There is no dead cycle beyond GAP_BITS.
- done: high for exactly one cycle, the cycle in which the last bit of the frame (last gap, parity or data bit) is on tx. It is never asserted in IDLE.
- busy = (state != IDLE).
- data_in changes after acceptance have no effect on the frame in flight.
- Reset mid-frame aborts immediately. tx drops to 0 asynchronously and no done is produced.
- Line property: a "1010" detector on tx fires exactly once at the end of each preamble. It may also fire inside the payload. Payload aliasing is the consumer's concern.

Optional Feature:
- Macro: FRAME_1010_TX_PARITY_EN.
- Defined:
  - PAR state is present.
  - One even-parity bit (XOR of the captured payload) is sent after the data, and P=1.
- Undefined:
  - No PAR state and no parity logic; P=0.
  - Port list is identical in both builds.

Decomposition:
- Shared package frame_1010_pkg holds:
  - state typedef (IDLE, PRE, DATA, PAR, GAP)
  - PREAMBLE = 4'b1010
  - PRE_LEN = 4
  - counter width function clog2
- One sub-module is natural: piso_shift_reg, a parameterised parallel-load, MSB-first shift register with load/shift enables. The FSM and bit counter stay in frame_1010_tx.

Test Plan:
- DATA_W=8, GAP_BITS=2, parity off; load 0xA5 once -> tx = 1010 10100101 00 over 14 cycles. done is high only on cycle 14, and ready returns high on cycle 15.
- Parity on, load 0xA7 -> tx = 1010 10100111 1 00 (parity 1), L=15. Load 0xA5 -> parity bit 0.
- GAP_BITS=0, load held high with data 0xFF then 0x00 -> back-to-back 1010 11111111 1010 00000000 with no idle cycle. Two done pulses, 12 cycles apart.
- Pulse load while busy (cycle 5 of a frame) -> ignored. The frame is unchanged and no second frame is sent.
- Assert rst at cycle 7 of a frame -> tx=0 and ready=0 immediately with no done. After release, ready=1 and a new load 0x3C transmits a clean frame.
- Attach the team's 1010 detector to tx with payload 0x00 -> exactly one detection per frame, coincident with the fourth preamble bit.
